// File: rtl/mem_stream_reader.sv
// Avalon-MM read initiator that streams a block of memory words out on a valid/ready interface.
// Define MEM_STREAM_READER_CHECKSUM_EN to add a running checksum of the accepted stream words.
module mem_stream_reader #(
   parameter int ADDR_W       = 14,
   parameter int DATA_W       = 64,
   parameter int FIFO_DEPTH   = 4,
   parameter int READ_LATENCY = 1
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                start,
   input  logic [ADDR_W-1:0]   base_addr,
   input  logic [ADDR_W-1:0]   word_count,
   input  logic                abort,
   output logic                busy,
   output logic                done,
`ifdef MEM_STREAM_READER_CHECKSUM_EN
   output logic [DATA_W-1:0]   checksum,
`endif
   output logic [ADDR_W-1:0]   mem_address,
   output logic                mem_chipselect,
   output logic                mem_write,
   output logic [DATA_W/8-1:0] mem_byteenable,
   input  logic [DATA_W-1:0]   mem_readdata,
   output logic [DATA_W-1:0]   st_data,
   output logic                st_valid,
   input  logic                st_ready
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]              state;
   logic [1:0]              state_nxt;
   logic [ADDR_W-1:0]       addr_q;
   logic [ADDR_W-1:0]       remaining_q;
   logic [CNT_W-1:0]        credit_cnt;
   logic [CNT_W-1:0]        credit_nxt;
   logic [CNT_W-1:0]        fifo_cnt;
   logic [PTR_W-1:0]        wr_ptr;
   logic [PTR_W-1:0]        rd_ptr;
   logic [READ_LATENCY-1:0] rd_pipe;
   logic [DATA_W-1:0]       fifo_mem [FIFO_DEPTH];

   logic start_ok;
   logic credit_ok;
   logic issue;
   logic push;
   logic pop;

   // A credit is held from the issue of a read until its word leaves the stream,
   // so the credit count is always FIFO occupancy plus reads in flight.
   assign start_ok   = (state == S_IDLE) && start && !abort;
   assign credit_ok  = credit_cnt < CNT_W'(FIFO_DEPTH);
   assign issue      = (state == S_ISSUE) && credit_ok && !abort;
   assign push       = rd_pipe[READ_LATENCY-1] && !abort;
   assign pop        = st_valid && st_ready;
   assign credit_nxt = credit_cnt + CNT_W'(issue) - CNT_W'(pop);

   assign busy           = (state == S_ISSUE) || (state == S_DRAIN);
   assign done           = (state == S_DONE);
   assign mem_address    = addr_q;
   assign mem_chipselect = issue;
   assign mem_write      = 1'b0;
   assign mem_byteenable = '1;

   assign st_valid = (fifo_cnt != '0);
   assign st_data  = st_valid ? fifo_mem[rd_ptr] : '0;

   always_comb begin
      // NOTE: assign a default before the case so every path drives state_nxt and no latch is inferred.
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (start_ok) state_nxt = (word_count == '0) ? S_DONE : S_ISSUE;
         end
         S_ISSUE: begin
            if (issue && (remaining_q == ADDR_W'(1))) state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            // Looking at the next credit value lets DONE follow the final handshake directly.
            if (credit_nxt == '0) state_nxt = S_DONE;
         end
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
      if (abort) state_nxt = S_IDLE;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= S_IDLE;
         addr_q      <= '0;
         remaining_q <= '0;
      end else begin
         state <= state_nxt;
         if (start_ok) begin
            addr_q      <= base_addr;
            remaining_q <= word_count;
         end else if (issue) begin
            addr_q      <= addr_q + ADDR_W'(1);
            remaining_q <= remaining_q - ADDR_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_pipe    <= '0;
         credit_cnt <= '0;
      end else if (abort) begin
         rd_pipe    <= '0;
         credit_cnt <= '0;
      end else begin
         rd_pipe[0] <= issue;
         for (int i = 1; i < READ_LATENCY; i++) begin
            rd_pipe[i] <= rd_pipe[i-1];
         end
         credit_cnt <= credit_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else if (abort) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         fifo_cnt <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // NOTE: the storage array has no reset; st_data is masked while the FIFO is empty instead.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= mem_readdata;
   end

`ifdef MEM_STREAM_READER_CHECKSUM_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         checksum <= '0;
      end else if (start_ok) begin
         checksum <= '0;
      end else if (pop) begin
         checksum <= checksum + st_data;
      end
   end
`endif

endmodule

// File: tb/tb_mem_stream_reader.sv
// Directed self-checking bench for mem_stream_reader with a one-cycle-latency memory model.
// Exercises the MEM_STREAM_READER_CHECKSUM_EN checksum only when that macro is defined.
module tb_mem_stream_reader;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic [13:0] base_addr;
   logic [13:0] word_count;
   logic        abort;
   logic        busy;
   logic        done;
   logic [13:0] mem_address;
   logic        mem_chipselect;
   logic        mem_write;
   logic [7:0]  mem_byteenable;
   logic [63:0] mem_readdata;
   logic [63:0] st_data;
   logic        st_valid;
   logic        st_ready;
`ifdef MEM_STREAM_READER_CHECKSUM_EN
   logic [63:0] checksum;
`endif

   mem_stream_reader dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .start          (start),
      .base_addr      (base_addr),
      .word_count     (word_count),
      .abort          (abort),
      .busy           (busy),
      .done           (done),
`ifdef MEM_STREAM_READER_CHECKSUM_EN
      .checksum       (checksum),
`endif
      .mem_address    (mem_address),
      .mem_chipselect (mem_chipselect),
      .mem_write      (mem_write),
      .mem_byteenable (mem_byteenable),
      .mem_readdata   (mem_readdata),
      .st_data        (st_data),
      .st_valid       (st_valid),
      .st_ready       (st_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [63:0] mem_model [16384];

   always @(posedge clk) begin
      if (mem_chipselect) mem_readdata <= mem_model[mem_address];
   end

   int n_checks = 0;
   int n_fail   = 0;

   int          cyc = 0;
   int          cs_n = 0;
   int          st_n = 0;
   int          vld_n = 0;
   int          done_n = 0;
   int          busy_n = 0;
   int          done_cyc = 0;
   int          credits = 0;
   int          max_out = 0;
   int          stall_err = 0;
   int          done_busy_err = 0;
   int          rdy_mode = 0;
   int          phase = 0;
   bit          prev_stall = 1'b0;
   logic [63:0] prev_data = '0;
   logic [63:0] done_cksum = '0;
   logic [13:0] addr_log [512];
   logic [63:0] st_log [512];
   int          st_cyc [512];

   int r_st0, r_cs0, r_d0, r_b0, r_start_cyc;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Sample outputs at the falling edge, then drive the next inputs just after the rising edge.
   task cycle();
      @(negedge clk);
      cyc++;
      if (mem_chipselect) begin
         if (cs_n < 512) addr_log[cs_n] = mem_address;
         cs_n++;
         credits++;
      end
      if (credits > max_out) max_out = credits;
      if (st_valid && st_ready) begin
         if (st_n < 512) begin
            st_log[st_n] = st_data;
            st_cyc[st_n] = cyc;
         end
         st_n++;
         credits--;
      end
      if (st_valid) vld_n++;
      if (prev_stall && (!st_valid || st_data != prev_data)) stall_err++;
      prev_stall = st_valid && !st_ready;
      prev_data  = st_data;
      if (done) begin
         done_n++;
         done_cyc = cyc;
         if (busy) done_busy_err++;
`ifdef MEM_STREAM_READER_CHECKSUM_EN
         done_cksum = checksum;
`endif
      end
      if (busy) busy_n++;
      @(posedge clk);
      #1;
      if (rdy_mode == 1) begin
         phase    = (phase + 1) % 4;
         st_ready = (phase == 0);
      end else begin
         st_ready = 1'b1;
      end
   endtask

   task run(input logic [13:0] base, input logic [13:0] wc, input int mode, input bit inject);
      rdy_mode   = mode;
      phase      = 0;
      st_ready   = 1'b1;
      r_st0      = st_n;
      r_cs0      = cs_n;
      r_d0       = done_n;
      r_b0       = busy_n;
      base_addr  = base;
      word_count = wc;
      start      = 1'b1;
      cycle();
      r_start_cyc = cyc;
      start       = 1'b0;
      for (int i = 0; i < 3000 && done_n == r_d0; i++) begin
         if (inject && i == 4) begin
            start      = 1'b1;
            base_addr  = 14'h3000;
            word_count = 14'd5;
         end else begin
            start = 1'b0;
         end
         cycle();
      end
      start = 1'b0;
      check("run_done_seen", 64'(done_n != r_d0), 64'd1);
      cycle();
   endtask

   initial begin
      int          errs;
      int          v0;
      int          d0;
      logic [13:0] a;

      for (int i = 0; i < 16384; i++) mem_model[i] = 64'(i);
      reset_n    = 1'b0;
      start      = 1'b0;
      abort      = 1'b0;
      base_addr  = '0;
      word_count = '0;
      st_ready   = 1'b1;

      #2;
      check("rst_busy",     64'(busy), 64'd0);
      check("rst_done",     64'(done), 64'd0);
      check("rst_cs",       64'(mem_chipselect), 64'd0);
      check("rst_write",    64'(mem_write), 64'd0);
      check("rst_be",       64'(mem_byteenable), 64'hFF);
      check("rst_addr",     64'(mem_address), 64'd0);
      check("rst_st_valid", 64'(st_valid), 64'd0);
      check("rst_st_data",  st_data, 64'd0);
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;

      // Basic run: 8 words from 0x10 with the sink always ready.
      run(14'h0010, 14'd8, 0, 1'b0);
      check("basic_count", 64'(st_n - r_st0), 64'd8);
      for (int i = 0; i < 8; i++) check("basic_word", st_log[r_st0+i], 64'h10 + 64'(i));
      check("basic_first_lat",  64'(st_cyc[r_st0] - r_start_cyc), 64'd3);
      check("basic_consec",     64'(st_cyc[r_st0+7] - st_cyc[r_st0]), 64'd7);
      check("basic_cs",         64'(cs_n - r_cs0), 64'd8);
      check("basic_done_once",  64'(done_n - r_d0), 64'd1);
      check("basic_done_after", 64'(done_cyc - st_cyc[r_st0+7]), 64'd1);

      // Backpressure with a stray start mid-transfer that must be ignored.
      max_out = 0;
      run(14'h0200, 14'd16, 1, 1'b1);
      check("bp_count", 64'(st_n - r_st0), 64'd16);
      errs = 0;
      for (int i = 0; i < 16; i++) if (st_log[r_st0+i] != 64'h200 + 64'(i)) errs++;
      check("bp_words",     64'(errs), 64'd0);
      check("bp_cs",        64'(cs_n - r_cs0), 64'd16);
      check("bp_max_out",   64'(max_out), 64'd4);
      check("bp_stall",     64'(stall_err), 64'd0);
      check("bp_done_once", 64'(done_n - r_d0), 64'd1);

      // Address wrap at the top of the word address space.
      run(14'h3FFE, 14'd4, 0, 1'b0);
      check("wrap_count", 64'(st_n - r_st0), 64'd4);
      for (int i = 0; i < 4; i++) begin
         a = 14'h3FFE + 14'(i);
         check("wrap_addr", 64'(addr_log[r_cs0+i]), 64'(a));
         check("wrap_word", st_log[r_st0+i], 64'(a));
      end

      // Zero word count completes without touching memory.
      run(14'h0123, 14'd0, 0, 1'b0);
      check("zero_cs",       64'(cs_n - r_cs0), 64'd0);
      check("zero_done_lat", 64'(done_cyc - r_start_cyc), 64'd1);
      check("zero_busy",     64'(busy_n - r_b0), 64'd0);
      check("zero_done_n",   64'(done_n - r_d0), 64'd1);

      // Abort after 5 stream words, with a start in the abort cycle that must be ignored.
      rdy_mode   = 0;
      st_ready   = 1'b1;
      r_st0      = st_n;
      d0         = done_n;
      base_addr  = 14'h0040;
      word_count = 14'd100;
      start      = 1'b1;
      cycle();
      start = 1'b0;
      for (int i = 0; i < 50 && (st_n - r_st0) < 5; i++) cycle();
      check("abort_reached_5", 64'((st_n - r_st0) >= 5), 64'd1);
      abort      = 1'b1;
      start      = 1'b1;
      base_addr  = 14'h0000;
      word_count = 14'd3;
      cycle();
      abort = 1'b0;
      start = 1'b0;
      check("abort_busy",     64'(busy), 64'd0);
      check("abort_st_valid", 64'(st_valid), 64'd0);
      check("abort_cs",       64'(mem_chipselect), 64'd0);
      v0 = vld_n;
      repeat (6) cycle();
      check("abort_no_valid", 64'(vld_n - v0), 64'd0);
      check("abort_no_done",  64'(done_n - d0), 64'd0);
      errs = 0;
      for (int i = 0; i < st_n - r_st0; i++) if (st_log[r_st0+i] != 64'h40 + 64'(i)) errs++;
      check("abort_words", 64'(errs), 64'd0);
      credits    = 0;
      prev_stall = 1'b0;

      run(14'h0000, 14'd2, 0, 1'b0);
      check("post_abort_count", 64'(st_n - r_st0), 64'd2);
      check("post_abort_w0",    st_log[r_st0], 64'd0);
      check("post_abort_w1",    st_log[r_st0+1], 64'd1);

      // Reset asserted mid-transfer clears the outputs immediately.
      base_addr  = 14'h0500;
      word_count = 14'd20;
      start      = 1'b1;
      cycle();
      start = 1'b0;
      repeat (5) cycle();
      reset_n = 1'b0;
      #1;
      check("midrst_busy",     64'(busy), 64'd0);
      check("midrst_st_valid", 64'(st_valid), 64'd0);
      check("midrst_st_data",  st_data, 64'd0);
      check("midrst_cs",       64'(mem_chipselect), 64'd0);
      repeat (2) cycle();
      reset_n    = 1'b1;
      credits    = 0;
      prev_stall = 1'b0;
      cycle();
      check("midrst_after_valid", 64'(st_valid), 64'd0);

`ifdef MEM_STREAM_READER_CHECKSUM_EN
      mem_model[14'h100] = 64'd1;
      mem_model[14'h101] = 64'd2;
      mem_model[14'h102] = 64'hFFFF_FFFF_FFFF_FFFF;
      run(14'h0100, 14'd3, 0, 1'b0);
      check("cksum_done", done_cksum, 64'd2);
      check("cksum_hold", checksum, 64'd2);
`endif

      check("done_while_busy", 64'(done_busy_err), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
